// File: rtl/lsu_wb.sv
// lsu_wb: load/store + writeback stage feeding the integer register file.
// Accepts one instruction from execute, issues a word-aligned memory request
// for loads/stores, aligns/extends load data and emits a one-cycle register
// file write pulse.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       execute handshake (ready only in IDLE)
//   is_load, is_store, funct3 operation decode (RV32I width/sign code)
//   addr, store_data          effective address and rs2 value
//   alu_result                writeback value for non-memory ops
//   rd_addr_i, rd_wen_i       destination register and write flag
//   mem_req_*                 memory request channel (valid/ready)
//   mem_resp_valid/rdata      read data or write ack, sampled only in WAIT
//   rd_data_o/rd_addr_o/rd_wen_o  register file write port
//   bus_err_o                 one-cycle pulse after a response timeout
//   misalign_o                (LSU_MISALIGN_TRAP_EN only) misaligned access pulse
//
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses
// instead of truncating the offending low address bits.
module lsu_wb #(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] alu_result,
    input  logic [4:0]  rd_addr_i,
    input  logic        rd_wen_i,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata,
    output logic [31:0] rd_data_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_wen_o,
    output logic        bus_err_o
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic        misalign_o
`endif
);

    localparam int unsigned CW = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_WB   = 3'd3,
        S_TRAP = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic          ld_q, st_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wmask_q;
    logic [4:0]    rd_addr_q;
    logic          rd_wen_q;
    logic [31:0]   data_q;
    logic [CW-1:0] cnt;
    logic          bus_err_q;

    logic        accept;
    logic        is_mem;
    logic        size_byte, size_half;
    logic [1:0]  eff_off;
    logic [3:0]  st_mask;
    logic [31:0] st_wdata;
    logic [31:0] ld_shift;
    logic [31:0] ld_aligned;
    logic        timeout;

    assign accept  = (state == S_IDLE) && in_valid;
    assign is_mem  = is_load || is_store;
    assign timeout = (state == S_WAIT) && !mem_resp_valid && (cnt == CW'(WAIT_MAX - 1));

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (size_half && addr[0]) ||
                        (!size_byte && !size_half && (addr[1:0] != 2'b00));
`endif

    // Access size decode and store lane placement; the lane offset drops
    // any low address bits that a halfword/word access cannot use.
    always_comb begin
        size_byte = (funct3[1:0] == 2'b00);
        size_half = (funct3[1:0] == 2'b01);
        eff_off   = 2'b00;
        st_mask   = 4'b1111;
        st_wdata  = store_data;
        if (size_byte) begin
            eff_off  = addr[1:0];
            st_mask  = 4'b0001 << eff_off;
            st_wdata = {4{store_data[7:0]}};
        end else if (size_half) begin
            eff_off  = {addr[1], 1'b0};
            st_mask  = 4'b0011 << eff_off;
            st_wdata = {2{store_data[15:0]}};
        end
    end

    // Load data alignment and extension from the latched offset/width code.
    always_comb begin
        ld_shift = mem_resp_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ld_aligned = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b100:  ld_aligned = {24'd0, ld_shift[7:0]};
            3'b001:  ld_aligned = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b101:  ld_aligned = {16'd0, ld_shift[15:0]};
            default: ld_aligned = mem_resp_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    if (!is_mem)
                        state_nxt = S_WB;
`ifdef LSU_MISALIGN_TRAP_EN
                    else if (misaligned)
                        state_nxt = S_TRAP;
`endif
                    else
                        state_nxt = S_REQ;
                end
            end
            S_REQ:  if (mem_req_ready) state_nxt = S_WAIT;
            S_WAIT: begin
                if (mem_resp_valid) state_nxt = ld_q ? S_WB : S_IDLE;
                else if (timeout)   state_nxt = S_IDLE;
            end
            S_WB:    state_nxt = S_IDLE;
            S_TRAP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state and latched transaction fields.
    always_comb begin
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        rd_wen_o      = 1'b0;
        mem_req_addr  = addr_q;
        mem_req_wen   = st_q;
        mem_req_wdata = wdata_q;
        mem_req_wmask = wmask_q;
        rd_data_o     = data_q;
        rd_addr_o     = rd_addr_q;
        bus_err_o     = bus_err_q;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_o    = (state == S_TRAP);
`endif
        case (state)
            S_IDLE:  in_ready      = 1'b1;
            S_REQ:   mem_req_valid = 1'b1;
            S_WB:    rd_wen_o      = rd_wen_q && (rd_addr_q != 5'd0);
            default: ;
        endcase
    end

    // Transaction capture, load data return, wait counter and timeout flag.
    // The timeout pulse is registered, so it shows in the cycle following
    // the last WAIT cycle (the FSM is already back in IDLE then).
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_q      <= 1'b0;
            st_q      <= 1'b0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            wmask_q   <= 4'd0;
            rd_addr_q <= 5'd0;
            rd_wen_q  <= 1'b0;
            data_q    <= 32'd0;
            cnt       <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= timeout;
            if (accept) begin
                ld_q      <= is_load;
                st_q      <= is_store && !is_load;
                f3_q      <= funct3;
                off_q     <= eff_off;
                addr_q    <= {addr[31:2], 2'b00};
                wdata_q   <= (is_store && !is_load) ? st_wdata : 32'd0;
                wmask_q   <= (is_store && !is_load) ? st_mask : 4'd0;
                rd_addr_q <= rd_addr_i;
                rd_wen_q  <= rd_wen_i;
                data_q    <= alu_result;
            end
            if (state == S_REQ && mem_req_ready)
                cnt <= '0;
            else if (state == S_WAIT && !mem_resp_valid)
                cnt <= cnt + CW'(1);
            if (state == S_WAIT && mem_resp_valid && ld_q)
                data_q <= ld_aligned;
        end
    end

endmodule
